regfile_wb_scheduler: RTL and testbench

//  Sequences the 8x12-bit register file's single write port for the 12-bit RISC core.

---
 rtl/regfile_wb_scheduler.sv | 97 +++++++++
 tb/tb_regfile_wb_scheduler.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler for the 8x12 register file: round-robin ALU/LSU arbiter, registered
// write stage and pending-write scoreboard. Optional WB_BYPASS_EN adds writeback forwarding.
module regfile_wb_scheduler #(
  parameter int DW      = 12,
  parameter int AW      = 3,
  parameter bit RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic              iss_wr,
  input  logic [AW-1:0]     iss_dst,
  input  logic [AW-1:0]     iss_src1,
  input  logic [AW-1:0]     iss_src2,
  output logic              iss_stall,
  input  logic              alu_valid,
  input  logic [AW-1:0]     alu_dst,
  input  logic [DW-1:0]     alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [AW-1:0]     lsu_dst,
  input  logic [DW-1:0]     lsu_data,
  output logic              lsu_ready,
  output logic              rf_wr_en,
  output logic [AW-1:0]     rf_wr_sel,
  output logic [DW-1:0]     rf_wr_data,
  output logic [2**AW-1:0]  busy_vec,
`ifdef WB_BYPASS_EN
  output logic              fwd_src1_hit,
  output logic              fwd_src2_hit,
  output logic [DW-1:0]     fwd_data,
`endif
  output logic              err_spurious
);

  localparam int NR = 2**AW;

  logic [NR-1:0] busy;
  logic          last_lsu;
  logic          src1_haz, src2_haz;
  logic          grant_alu, grant_lsu, any_grant, issue_set;
  logic [AW-1:0] gnt_dst;
  logic [DW-1:0] gnt_data;
  logic [NR-1:0] set_mask, clr_mask;

  assign busy_vec = busy;

  // A source matching the register being written this cycle is served by forwarding.
`ifdef WB_BYPASS_EN
  assign fwd_src1_hit = rf_wr_en & (rf_wr_sel == iss_src1);
  assign fwd_src2_hit = rf_wr_en & (rf_wr_sel == iss_src2);
  assign fwd_data     = rf_wr_data;
  assign src1_haz     = busy[iss_src1] & ~fwd_src1_hit;
  assign src2_haz     = busy[iss_src2] & ~fwd_src2_hit;
`else
  assign src1_haz     = busy[iss_src1];
  assign src2_haz     = busy[iss_src2];
`endif

  assign iss_stall = iss_valid & (src1_haz | src2_haz | (iss_wr & busy[iss_dst]));
  assign issue_set = iss_valid & iss_wr & ~iss_stall;

  // last_lsu records who won the previous grant; on contention the other side wins.
  assign grant_alu = alu_valid & (~lsu_valid | last_lsu);
  assign grant_lsu = lsu_valid & (~alu_valid | ~last_lsu);
  assign any_grant = grant_alu | grant_lsu;
  assign alu_ready = grant_alu & rst_n;
  assign lsu_ready = grant_lsu & rst_n;

  assign gnt_dst  = grant_lsu ? lsu_dst  : alu_dst;
  assign gnt_data = grant_lsu ? lsu_data : alu_data;

  assign set_mask = issue_set ? (NR'(1) << iss_dst)   : '0;
  assign clr_mask = rf_wr_en  ? (NR'(1) << rf_wr_sel) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= '0;
      rf_wr_en     <= 1'b0;
      rf_wr_sel    <= '0;
      rf_wr_data   <= '0;
      err_spurious <= 1'b0;
      last_lsu     <= ~RR_INIT;
    end else begin
      busy     <= (busy & ~clr_mask) | set_mask;
      rf_wr_en <= any_grant;
      if (any_grant) begin
        rf_wr_sel  <= gnt_dst;
        rf_wr_data <= gnt_data;
        last_lsu   <= grant_lsu;
        if (!busy[gnt_dst])
          err_spurious <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios plus randomized traffic
// compared against a scoreboard model kept in the bench. Honours WB_BYPASS_EN when defined.
module tb_regfile_wb_scheduler;

  localparam int DW      = 12;
  localparam int AW      = 3;
  localparam bit RR_INIT = 1'b0;

  logic          clk, rst_n;
  logic          iss_valid, iss_wr;
  logic [AW-1:0] iss_dst, iss_src1, iss_src2;
  logic          iss_stall;
  logic          alu_valid, lsu_valid, alu_ready, lsu_ready;
  logic [AW-1:0] alu_dst, lsu_dst;
  logic [DW-1:0] alu_data, lsu_data;
  logic          rf_wr_en;
  logic [AW-1:0] rf_wr_sel;
  logic [DW-1:0] rf_wr_data;
  logic [7:0]    busy_vec;
  logic          err_spurious;
`ifdef WB_BYPASS_EN
  logic          fwd_src1_hit, fwd_src2_hit;
  logic [DW-1:0] fwd_data;
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference state: which registers await a write, what the write port shows, who won last.
  logic [7:0]    m_busy;
  logic          m_wen;
  logic [AW-1:0] m_sel;
  logic [DW-1:0] m_data;
  logic          m_err;
  int            m_last;

  regfile_wb_scheduler #(.DW(DW), .AW(AW), .RR_INIT(RR_INIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_dst(iss_dst),
    .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_stall(iss_stall),
    .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_dst(lsu_dst), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel), .rf_wr_data(rf_wr_data),
    .busy_vec(busy_vec),
`ifdef WB_BYPASS_EN
    .fwd_src1_hit(fwd_src1_hit), .fwd_src2_hit(fwd_src2_hit), .fwd_data(fwd_data),
`endif
    .err_spurious(err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit src_hazard(logic [AW-1:0] s);
    return m_busy[s] && !(BYPASS && m_wen && m_sel == s);
  endfunction

  function automatic bit exp_stall();
    return iss_valid && (src_hazard(iss_src1) || src_hazard(iss_src2) ||
                         (iss_wr && m_busy[iss_dst]));
  endfunction

  // 0 = nobody, 1 = ALU, 2 = LSU
  function automatic int exp_grant();
    if (alu_valid && lsu_valid) return (m_last == 2) ? 1 : 2;
    if (alu_valid) return 1;
    if (lsu_valid) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = '0; m_wen = 0; m_sel = '0; m_data = '0; m_err = 0;
    m_last = (RR_INIT == 1'b0) ? 2 : 1;
  endtask

  task automatic model_edge();
    logic [7:0]    nb;
    int            g;
    logic [AW-1:0] gd;
    g  = exp_grant();
    nb = m_busy;
    if (m_wen) nb[m_sel] = 1'b0;
    if (iss_valid && iss_wr && !exp_stall()) nb[iss_dst] = 1'b1;
    if (g != 0) begin
      gd = (g == 1) ? alu_dst : lsu_dst;
      if (!m_busy[gd]) m_err = 1'b1;
      m_wen  = 1'b1;
      m_sel  = gd;
      m_data = (g == 1) ? alu_data : lsu_data;
      m_last = g;
    end else begin
      m_wen = 1'b0;
    end
    m_busy = nb;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic iv, input logic iw, input int id, input int s1, input int s2,
                       input logic av, input int ad, input logic [DW-1:0] adat,
                       input logic lv, input int ld, input logic [DW-1:0] ldat);
    iss_valid = iv; iss_wr = iw;
    iss_dst = AW'(id); iss_src1 = AW'(s1); iss_src2 = AW'(s2);
    alu_valid = av; alu_dst = AW'(ad); alu_data = adat;
    lsu_valid = lv; lsu_dst = AW'(ld); lsu_data = ldat;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, '0, 0, 0, '0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [31:0] got;
    got = {iss_stall, alu_ready, lsu_ready, rf_wr_en, rf_wr_sel, rf_wr_data, busy_vec, err_spurious};
    n_vec++;
    if (got !== 32'd0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", got);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    drive(1, 1, 3, 0, 0, 0, 0, '0, 0, 0, '0);
    tick();
    idle();
    n_vec++;
    if (busy_vec !== 8'h08) begin
      n_err++; $display("[TB] FAIL issue_busy: got %h expected 08", busy_vec);
    end
    drive(0, 0, 0, 0, 0, 1, 3, 12'hABC, 0, 0, '0);
    n_vec++;
    if ({alu_ready, lsu_ready} !== 2'b10) begin
      n_err++; $display("[TB] FAIL alu_ready_N: got %b expected 10", {alu_ready, lsu_ready});
    end
    tick();
    idle();
    n_vec++;
    if ({rf_wr_en, rf_wr_sel, rf_wr_data, busy_vec} !== {1'b1, 3'd3, 12'hABC, 8'h08}) begin
      n_err++;
      $display("[TB] FAIL write_N1: got en=%b sel=%0d data=%h busy=%h expected en=1 sel=3 data=abc busy=08",
               rf_wr_en, rf_wr_sel, rf_wr_data, busy_vec);
    end
    tick();
    n_vec++;
    if ({rf_wr_en, busy_vec, err_spurious} !== 10'd0) begin
      n_err++;
      $display("[TB] FAIL retire_N2: got en=%b busy=%h err=%b expected all 0",
               rf_wr_en, busy_vec, err_spurious);
    end
    n_vec++;
    if ({rf_wr_sel, rf_wr_data} !== {3'd3, 12'hABC}) begin
      n_err++; $display("[TB] FAIL hold_idle: got sel=%0d data=%h expected 3 abc", rf_wr_sel, rf_wr_data);
    end
  endtask

  task automatic test_round_robin();
    int alu_q[$], lsu_q[$];
    int side;
    do_reset();
    alu_q = '{1, 2, 7};
    lsu_q = '{4, 5, 0};
    foreach (alu_q[i]) begin drive(1, 1, alu_q[i], 3, 3, 0, 0, '0, 0, 0, '0); tick(); end
    foreach (lsu_q[i]) begin drive(1, 1, lsu_q[i], 3, 3, 0, 0, '0, 0, 0, '0); tick(); end
    for (int k = 0; k < 6; k++) begin
      side = RR_INIT ^ (k % 2);
      drive(0, 0, 0, 0, 0, 1, alu_q.size() ? alu_q[0] : 6, DW'(100 + k),
            1, lsu_q.size() ? lsu_q[0] : 6, DW'(200 + k));
      n_vec++;
      if ({alu_ready, lsu_ready} !== ((side == 0) ? 2'b10 : 2'b01)) begin
        n_err++;
        $display("[TB] FAIL rr_grant_%0d: got alu=%b lsu=%b expected side %0d",
                 k, alu_ready, lsu_ready, side);
      end
      if (k > 0) begin
        n_vec++;
        if (rf_wr_en !== 1'b1) begin
          n_err++; $display("[TB] FAIL rr_throughput_%0d: got en=%b expected 1", k, rf_wr_en);
        end
      end
      if (side == 0 && alu_q.size()) void'(alu_q.pop_front());
      if (side == 1 && lsu_q.size()) void'(lsu_q.pop_front());
      tick();
    end
    idle();
    tick();
    n_vec++;
    if ({busy_vec, err_spurious} !== 9'd0) begin
      n_err++; $display("[TB] FAIL rr_drain: got busy=%h err=%b expected 0", busy_vec, err_spurious);
    end
  endtask

  task automatic test_raw_stall();
    do_reset();
    drive(1, 1, 5, 0, 0, 0, 0, '0, 0, 0, '0);
    tick();
    drive(1, 0, 0, 5, 0, 0, 0, '0, 0, 0, '0);
    n_vec++;
    if (iss_stall !== 1'b1) begin
      n_err++; $display("[TB] FAIL raw_pending: got %b expected 1", iss_stall);
    end
    tick();
    drive(1, 0, 0, 5, 0, 1, 5, 12'h5A5, 0, 0, '0);
    n_vec++;
    if ({iss_stall, alu_ready} !== 2'b11) begin
      n_err++; $display("[TB] FAIL raw_grant_N: got stall=%b ready=%b expected 1 1", iss_stall, alu_ready);
    end
    tick();
    drive(1, 0, 0, 5, 0, 0, 0, '0, 0, 0, '0);
    n_vec++;
    if (iss_stall !== !BYPASS) begin
      n_err++; $display("[TB] FAIL raw_write_N1: got stall=%b expected %b", iss_stall, !BYPASS);
    end
`ifdef WB_BYPASS_EN
    n_vec++;
    if ({fwd_src1_hit, fwd_src2_hit, fwd_data} !== {2'b10, 12'h5A5}) begin
      n_err++;
      $display("[TB] FAIL raw_forward: got hit1=%b hit2=%b data=%h expected 1 0 5a5",
               fwd_src1_hit, fwd_src2_hit, fwd_data);
    end
`endif
    tick();
    drive(1, 0, 0, 5, 0, 0, 0, '0, 0, 0, '0);
    n_vec++;
    if (iss_stall !== 1'b0) begin
      n_err++; $display("[TB] FAIL raw_N2: got %b expected 0", iss_stall);
    end
    tick();
  endtask

  task automatic test_waw();
    do_reset();
    drive(1, 1, 2, 0, 0, 0, 0, '0, 0, 0, '0);
    tick();
    drive(1, 1, 2, 0, 0, 1, 2, 12'h222, 0, 0, '0);
    n_vec++;
    if (iss_stall !== 1'b1) begin
      n_err++; $display("[TB] FAIL waw_pending: got %b expected 1", iss_stall);
    end
    tick();
    drive(1, 1, 2, 0, 0, 0, 0, '0, 0, 0, '0);
    n_vec++;
    if (iss_stall !== 1'b1) begin
      n_err++; $display("[TB] FAIL waw_during_write: got %b expected 1", iss_stall);
    end
    tick();
    drive(1, 1, 2, 0, 0, 0, 0, '0, 0, 0, '0);
    n_vec++;
    if (iss_stall !== 1'b0) begin
      n_err++; $display("[TB] FAIL waw_cleared: got %b expected 0", iss_stall);
    end
    tick();
    idle();
    n_vec++;
    if (busy_vec !== 8'h04) begin
      n_err++; $display("[TB] FAIL waw_reissue: got %h expected 04", busy_vec);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, '0, 1, 6, 12'h666);
    n_vec++;
    if ({alu_ready, lsu_ready} !== 2'b01) begin
      n_err++; $display("[TB] FAIL spur_ready: got %b expected 01", {alu_ready, lsu_ready});
    end
    tick();
    idle();
    n_vec++;
    if ({rf_wr_en, rf_wr_sel, rf_wr_data, err_spurious} !== {1'b1, 3'd6, 12'h666, 1'b1}) begin
      n_err++;
      $display("[TB] FAIL spur_write: got en=%b sel=%0d data=%h err=%b expected 1 6 666 1",
               rf_wr_en, rf_wr_sel, rf_wr_data, err_spurious);
    end
    repeat (3) tick();
    n_vec++;
    if (err_spurious !== 1'b1) begin
      n_err++; $display("[TB] FAIL spur_sticky: got %b expected 1", err_spurious);
    end
  endtask

  task automatic test_random();
    int idx[$];
    int ad, ld;
    logic [31:0] got, exp;
    logic av, lv;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      idx = {};
      for (int r = 0; r < 8; r++) if (m_busy[r]) idx.push_back(r);
      av = idx.size() > 0 && ($urandom_range(0, 3) != 0);
      lv = idx.size() > 0 && ($urandom_range(0, 2) != 0);
      ad = idx.size() ? idx[$urandom_range(0, idx.size() - 1)] : 0;
      ld = idx.size() ? idx[$urandom_range(0, idx.size() - 1)] : 0;
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7),
            av, ad, DW'($urandom), lv, ld, DW'($urandom));
      got = {iss_stall, alu_ready, lsu_ready, rf_wr_en, rf_wr_sel, rf_wr_data, busy_vec, err_spurious};
      exp = {exp_stall(), exp_grant() == 1, exp_grant() == 2, m_wen, m_sel, m_data, m_busy, m_err};
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("[TB] FAIL random_cycle_%0d: got %h expected %h", c, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] got;
    do_reset();
    for (int r = 0; r < 8; r++) begin drive(1, 1, r, r, r, 0, 0, '0, 0, 0, '0); tick(); end
    drive(0, 0, 0, 0, 0, 1, 0, 12'h123, 0, 0, '0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 1, 12'h456, 0, 0, '0);
    n_vec++;
    if ({rf_wr_en, busy_vec, alu_ready} !== {1'b1, 8'hFF, 1'b1}) begin
      n_err++;
      $display("[TB] FAIL midop_setup: got en=%b busy=%h ready=%b expected 1 ff 1",
               rf_wr_en, busy_vec, alu_ready);
    end
    rst_n = 1'b0;
    #1;
    got = {iss_stall, alu_ready, lsu_ready, rf_wr_en, rf_wr_sel, rf_wr_data, busy_vec, err_spurious};
    n_vec++;
    if (got !== 32'd0) begin
      n_err++; $display("[TB] FAIL midop_reset: got %h expected 0", got);
    end
    idle();
    rst_n = 1'b1;
    model_reset();
    tick();
    n_vec++;
    if ({rf_wr_en, busy_vec} !== 9'd0) begin
      n_err++; $display("[TB] FAIL midop_no_retry: got en=%b busy=%h expected 0", rf_wr_en, busy_vec);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    iss_valid = 0; iss_wr = 0; iss_dst = '0; iss_src1 = '0; iss_src2 = '0;
    alu_valid = 0; alu_dst = '0; alu_data = '0;
    lsu_valid = 0; lsu_dst = '0; lsu_data = '0;
    model_reset();
    #2;
    test_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_single_write();
    test_round_robin();
    test_raw_stall();
    test_waw();
    test_spurious();
    test_random();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
